// File: rtl/i2s_tdm_sched.sv
// TDM slot scheduler: buffers one sample per source channel and serves
// encoder channel requests, substituting mute or repeat data on underrun.
module i2s_tdm_sched #(
  parameter int NR_CHANNELS      = 4,
  parameter int INPUT_WIDTH      = 24,
  parameter int MUTE_ON_UNDERRUN = 1,
  parameter int CHANNEL_WIDTH    = (NR_CHANNELS > 1) ? $clog2(NR_CHANNELS) : 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               enable,
  input  logic [NR_CHANNELS*INPUT_WIDTH-1:0] s_d,
  input  logic [NR_CHANNELS-1:0]             s_dv,
  output logic [NR_CHANNELS-1:0]             s_dr,
  input  logic [CHANNEL_WIDTH-1:0]           enc_ch,
  input  logic                               enc_chv,
  output logic                               enc_chr,
  output logic [INPUT_WIDTH-1:0]             enc_d,
  output logic                               enc_dv,
  input  logic                               enc_dr,
  output logic                               underrun,
  output logic [15:0]                        underrun_cnt,
  input  logic                               clear
);

  if (NR_CHANNELS < 2) begin : g_bad_cfg
    $fatal(1, "i2s_tdm_sched: NR_CHANNELS must be >= 2");
  end

  typedef enum logic [1:0] {IDLE, ACK, SERVE} state_t;

  state_t                   state_q, state_d;
  logic [CHANNEL_WIDTH-1:0] ch_q;
  logic [INPUT_WIDTH-1:0]   buf_q  [NR_CHANNELS];
  logic [INPUT_WIDTH-1:0]   last_q [NR_CHANNELS];
  logic [NR_CHANNELS-1:0]   full_q;
  logic                     take_q;
  logic                     ch_ok;
  logic                     sel_full, take, sel_ur;
  logic [INPUT_WIDTH-1:0]   sel_d;
  logic                     deliver;

  assign s_dr    = ~full_q;
  assign deliver = (state_q == SERVE) && enc_dv && enc_dr;

  // Only a non-power-of-two channel count can produce an out-of-range request.
  if ((1 << CHANNEL_WIDTH) > NR_CHANNELS) begin : g_ch_chk
    assign ch_ok = (32'(ch_q) < NR_CHANNELS);
  end else begin : g_ch_all
    assign ch_ok = 1'b1;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    sel_full = 1'b0;
    if (ch_ok) sel_full = full_q[ch_q];
    take   = enable && sel_full;
    sel_ur = !ch_ok || (enable && !sel_full);
    sel_d  = '0;
    if (take)
      sel_d = buf_q[ch_q];
    else if (MUTE_ON_UNDERRUN == 0 && ch_ok)
      sel_d = last_q[ch_q];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enc_chv) state_d = ACK;
      ACK:     state_d = SERVE;
      SERVE:   if (enc_dv && enc_dr) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // enc_chr and enc_dv are registered: chr follows the ACK cycle, dv one cycle later.
  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ch_q         <= '0;
      enc_chr      <= 1'b0;
      enc_dv       <= 1'b0;
      enc_d        <= '0;
      take_q       <= 1'b0;
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      state_q <= state_d;
      enc_chr <= (state_q == ACK);
      enc_dv  <= (state_q == SERVE) && !(enc_dv && enc_dr);
      if (state_q == IDLE && enc_chv) ch_q <= enc_ch;
      if (state_q == ACK) begin
        enc_d  <= sel_d;
        take_q <= take;
      end
      if (clear) begin
        underrun     <= 1'b0;
        underrun_cnt <= '0;
      end else if (state_q == ACK && sel_ur) begin
        underrun <= 1'b1;
        if (underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
      end
    end
  end

  // NOTE: the sample buffers and last-sample memories are reset because repeat-on-underrun
  // reads them back and must return zero on a channel that has never delivered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= '0;
      for (int k = 0; k < NR_CHANNELS; k++) begin
        buf_q[k]  <= '0;
        last_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NR_CHANNELS; k++) begin
        if (s_dv[k] && !full_q[k]) begin
          buf_q[k]  <= s_d[k*INPUT_WIDTH +: INPUT_WIDTH];
          full_q[k] <= 1'b1;
        end
      end
      // A full channel cannot load in the same cycle, so this never races a reload.
      if (deliver && take_q) begin
        full_q[ch_q] <= 1'b0;
        last_q[ch_q] <= enc_d;
      end
    end
  end

endmodule
